// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard/forwarding controller.
// A scoreboard entry is a flat vector {rd, is_load, we, valid}; the field offsets are below.
package hazard_pkg;

    localparam int FWD_REGFILE = 0;

    localparam int STG_X  = 1;
    localparam int STG_M  = 2;
    localparam int STG_WB = 3;

    localparam int ENT_VALID = 0;
    localparam int ENT_WE    = 1;
    localparam int ENT_LOAD  = 2;
    localparam int ENT_RD    = 3;

    // Same layout as the flat entry vector when the register address is 5 bits wide.
    typedef struct packed {
        logic [4:0] rd;
        logic       is_load;
        logic       we;
        logic       valid;
    } sb_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ent_width(input int reg_aw);
        return ENT_RD + reg_aw;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Priority matcher for one source operand against all scoreboard entries.
// Reports the youngest producer; a producer in the last stage is served by the regfile.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int SELW   = sel_width(DEPTH),
    parameter int ENTW   = ent_width(REG_AW)
) (
    input  logic [REG_AW-1:0]     rs,
    input  logic                  used,
    input  logic [DEPTH*ENTW-1:0] entries,
    output logic                  hit,
    output logic [SELW-1:0]       fwd_j,
    output logic                  is_load
);

    logic [DEPTH-1:0] match;
    logic             any_match;
    int               youngest;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = used
                             & (rs != '0)
                             & entries[gi*ENTW + ENT_VALID]
                             & entries[gi*ENTW + ENT_WE]
                             & (entries[gi*ENTW + ENT_RD +: REG_AW] == rs);
        end
    endgenerate

    always_comb begin
        any_match = 1'b0;
        youngest  = 0;
        // Scan oldest to youngest so the smallest index is the one left standing.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                any_match = 1'b1;
                youngest  = k;
            end
        end
        hit     = any_match && (youngest != DEPTH - 1);
        fwd_j   = hit ? SELW'(youngest + 2) : '0;
        is_load = any_match & entries[youngest*ENTW + ENT_LOAD];
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: in-flight destination scoreboard, per-source bypass
// selects, load-use stall, branch/jump squash window and writeback enables.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH       = STG_WB,
    parameter int NUM_SRC     = 2,
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int KILL_CYCLES = 1,
    parameter int SELW        = sel_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      kill,
    output logic                      stall,
    output logic                      squash,
    output logic                      issue_valid,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [DEPTH-1:0]          stage_valid,
    output logic                      wb_we,
    output logic [REG_AW-1:0]         wb_rd
);

    localparam int ENTW = ent_width(REG_AW);
    localparam int KW   = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;
    localparam int WB_BASE = (DEPTH - 1) * ENTW;
    // A load produced in stage j is only usable once j reaches this stage.
    localparam logic [SELW-1:0] STALL_LIM = SELW'(STG_M + LOAD_LAT);

    logic [DEPTH*ENTW-1:0]   ent_q, ent_d;
    logic [KW-1:0]           kill_cnt_q, kill_cnt_d;
    logic [NUM_SRC*SELW-1:0] fwd_sel_q, fwd_sel_d;

    logic                    issue;
    logic [ENTW-1:0]         new_ent;
    logic [NUM_SRC-1:0]      src_hit;
    logic [NUM_SRC-1:0]      src_load;
    logic [NUM_SRC-1:0]      src_hazard;
    logic [NUM_SRC*SELW-1:0] src_j;
    logic [NUM_SRC*SELW-1:0] sel_now;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_match #(
                .DEPTH  (DEPTH),
                .REG_AW (REG_AW),
                .SELW   (SELW),
                .ENTW   (ENTW)
            ) u_match (
                .rs      (id_rs[gi*REG_AW +: REG_AW]),
                .used    (id_rs_used[gi]),
                .entries (ent_q),
                .hit     (src_hit[gi]),
                .fwd_j   (src_j[gi*SELW +: SELW]),
                .is_load (src_load[gi])
            );

            assign src_hazard[gi] = src_hit[gi] & src_load[gi]
                                  & (src_j[gi*SELW +: SELW] < STALL_LIM);
            assign sel_now[gi*SELW +: SELW] = src_hit[gi] ? src_j[gi*SELW +: SELW]
                                                          : SELW'(FWD_REGFILE);
        end

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign stage_valid[gi] = ent_q[gi*ENTW + ENT_VALID];
        end
    endgenerate

    always_comb begin
        squash = ~reset & (kill | (kill_cnt_q != '0));
        // A squashed instruction is thrown away, so it must never hold the front end.
        stall  = ~reset & ~squash & id_valid & (|src_hazard);
        issue  = id_valid & ~stall & ~squash;

        new_ent = '0;
        if (issue) begin
            new_ent[ENT_VALID]         = 1'b1;
            new_ent[ENT_WE]            = id_we;
            new_ent[ENT_LOAD]          = id_is_load;
            new_ent[ENT_RD +: REG_AW]  = id_rd;
        end
        ent_d = {ent_q[WB_BASE-1:0], new_ent};

        fwd_sel_d = issue ? sel_now : '0;

        kill_cnt_d = kill_cnt_q;
        if (kill) begin
            kill_cnt_d = KW'(KILL_CYCLES);
        end else if (kill_cnt_q != '0) begin
            kill_cnt_d = kill_cnt_q - KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q      <= '0;
            kill_cnt_q <= '0;
            fwd_sel_q  <= '0;
        end else begin
            ent_q      <= ent_d;
            kill_cnt_q <= kill_cnt_d;
            fwd_sel_q  <= fwd_sel_d;
        end
    end

    assign issue_valid = ent_q[(STG_X-1)*ENTW + ENT_VALID];
    assign fwd_sel     = fwd_sel_q;
    assign wb_rd       = ent_q[WB_BASE + ENT_RD +: REG_AW];
    assign wb_we       = ent_q[WB_BASE + ENT_VALID] & ent_q[WB_BASE + ENT_WE]
                       & (wb_rd != '0);

endmodule
